tx_serial_escalonador: RTL and testbench
========================================

TX_SERIAL_ESCALONADOR -- requirements
Module: tx_serial_escalonador

Interface
REQ-001 Parameter CLKS_POR_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clock  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; also drives the transmit datapath reset.
REQ-005 req_a / req_b  in  1 each  transmit request from requester A / B, level-held until that requester's ack pulse.
REQ-006 dados_a / dados_b  in  8 each  byte for A / B, stable while the matching req is high.
REQ-007 fim  in  1  datapath bit counter terminal flag (high when count = 12).
REQ-008 zera, carrega  out  1 each  datapath counter clear / shift-register load.
REQ-009 conta, desloca  out  1 each  datapath count enable / shift enable.
REQ-010 dados_ascii  out  8  registered byte presented to the datapath.
REQ-011 ack_a / ack_b  out  1 each  one-cycle grant/capture pulse to A / B.
REQ-012 pronto  out  1  one-cycle end-of-frame pulse.
REQ-013 ocupado  out  1  high in every state except INICIAL.
REQ-014 db_estado  out  4  state code for debug.

Function
REQ-015 FSM states and codes: INICIAL=0, PREPARACAO=1, ESPERA=2, TRANSMISSAO=3, FINAL=4; unused codes shall go to INICIAL.
REQ-016 INICIAL: if req_a or req_b is high, go to PREPARACAO next cycle and record the grant; otherwise stay.
REQ-017 Arbitration: round-robin; a lone requester is granted; when both request, grant the one not granted last; the last-granted register resets to B, so A wins first.
REQ-018 PREPARACAO (1 cycle): assert zera=1 and carrega=1; pulse ack of the granted requester; load dados_ascii from the granted dados input so the datapath loads the new byte; hold the bit timer at 0; go to ESPERA.
REQ-019 Bit timer: 16-bit counter that runs in ESPERA and TRANSMISSAO; tick when value = CLKS_POR_BIT-1, then wrap to 0; held at 0 in all other states.
REQ-020 ESPERA: if fim=1, go to FINAL (fim has priority over tick); else if tick, go to TRANSMISSAO; else stay.
REQ-021 TRANSMISSAO (1 cycle): assert desloca=1 and conta=1; go to ESPERA.
REQ-022 Bit period is exactly CLKS_POR_BIT clocks; with PREPARACAO at cycle t0, the k-th desloca pulse occurs at t0+k*CLKS_POR_BIT+1 for k=1..12.
REQ-023 FINAL (1 cycle): assert pronto=1; update the last-granted register; go to INICIAL. Pronto occurs at t0+12*CLKS_POR_BIT+3.
REQ-024 zera, carrega, conta, desloca, ack_a, ack_b and pronto shall be decoded from state only (Moore) and are low in every state not listed for them.
REQ-025 req inputs are ignored outside INICIAL; a req still high in the cycle after FINAL is a new request.
REQ-026 dados_ascii shall hold its value from PREPARACAO until the next PREPARACAO.

Reset
REQ-027 While reset=1, outputs immediately (asynchronously) take these values: state=INICIAL, bit timer=0, last-granted=B, dados_ascii=8'h00; every control/handshake output is 0, db_estado=0, ocupado=0.
REQ-028 Reset asserted mid-frame shall abort the frame with no pronto and no further ack; after release, the controller waits in INICIAL.

Verification (CLKS_POR_BIT=4)
REQ-029 Single request: req_a=1, dados_a=8'h55 in INICIAL, with PREPARACAO at t0 -> ack_a at t0; dados_ascii=8'h55; desloca pulses at t0+5, t0+9, ..., t0+49; pronto at t0+51; line sequence 1, 0, 1,0,1,0,1,0,1,0, parity bit, 1.
REQ-030 Simultaneous requests: req_a=req_b=1 held -> frames alternate A, B, A; ack_a comes first; frames are back-to-back with one INICIAL cycle between them.
REQ-031 fim priority: fim forced to 1 in the same ESPERA cycle as a tick -> next state is FINAL; no desloca pulse.
REQ-032 Reset mid-frame: assert reset at t0+20 -> all outputs 0 and db_estado=0 in the same cycle; no pronto; with req_b=1 after release -> ack_b in the first PREPARACAO.
REQ-033 Idle: no requests for 100 cycles -> state stays INICIAL; all strobes stay 0 and the bit timer stays 0.

Source files
------------

// File: rtl/tx_serial_escalonador.sv
// -----------------------------------------------------------------------------
// tx_serial_escalonador
// Transmit controller for a serial datapath shared by two requesters (A, B).
// A round-robin arbiter picks a requester, the byte is presented to the
// datapath, and one desloca/conta pulse is issued every CLKS_POR_BIT clocks
// until the datapath bit counter reports fim. A one-cycle pronto closes the
// frame.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   req_a/req_b  in   transmit requests, level-held until the matching ack
//   dados_a/b    in   8-bit bytes for A / B
//   fim          in   datapath bit counter terminal flag
//   zera         out  datapath counter clear
//   carrega      out  datapath shift-register load
//   conta        out  datapath count enable
//   desloca      out  datapath shift enable
//   dados_ascii  out  byte presented to the datapath (held between frames)
//   ack_a/ack_b  out  one-cycle grant pulse
//   pronto       out  one-cycle end-of-frame pulse
//   ocupado      out  high whenever the controller is not idle
//   db_estado    out  state code for debug
// -----------------------------------------------------------------------------
module tx_serial_escalonador #(
    parameter int CLKS_POR_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] dados_a,
    input  logic [7:0] dados_b,
    input  logic       fim,
    output logic       zera,
    output logic       carrega,
    output logic       conta,
    output logic       desloca,
    output logic [7:0] dados_ascii,
    output logic       ack_a,
    output logic       ack_b,
    output logic       pronto,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        INICIAL     = 3'd0,
        PREPARACAO  = 3'd1,
        ESPERA      = 3'd2,
        TRANSMISSAO = 3'd3,
        FINAL       = 3'd4
    } estado_t;

    localparam logic [15:0] TIMER_MAX = 16'(CLKS_POR_BIT - 1);

    estado_t     estado;
    estado_t     proximo;
    logic [15:0] timer;
    logic        tick;
    logic        ultimo_b;   // last granted requester was B
    logic        concede_b;  // requester granted for the frame in progress is B
    logic        escolha_b;  // arbitration result for the current cycle

    assign tick      = (timer == TIMER_MAX);
    assign db_estado = {1'b0, estado};

    // Round-robin choice: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        escolha_b = 1'b0;
        if (req_a && req_b) begin
            escolha_b = ~ultimo_b;
        end else if (req_b) begin
            escolha_b = 1'b1;
        end else begin
            escolha_b = 1'b0;
        end
    end

    // Next-state logic; fim has priority over the bit tick in ESPERA.
    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL: begin
                if (req_a || req_b) begin
                    proximo = PREPARACAO;
                end else begin
                    proximo = INICIAL;
                end
            end
            PREPARACAO: proximo = ESPERA;
            ESPERA: begin
                if (fim) begin
                    proximo = FINAL;
                end else if (tick) begin
                    proximo = TRANSMISSAO;
                end else begin
                    proximo = ESPERA;
                end
            end
            TRANSMISSAO: proximo = ESPERA;
            FINAL:       proximo = INICIAL;
            default:     proximo = INICIAL;
        endcase
    end

    // State, bit timer, arbitration history and registered Moore outputs.
    // Outputs are registered from the next state so each one is a flop that
    // reflects the current state in the following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= INICIAL;
            timer       <= 16'd0;
            ultimo_b    <= 1'b1;
            concede_b   <= 1'b0;
            dados_ascii <= 8'h00;
            zera        <= 1'b0;
            carrega     <= 1'b0;
            conta       <= 1'b0;
            desloca     <= 1'b0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            pronto      <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            estado <= proximo;

            // Timer runs only while a bit is being timed; wraps on tick.
            if ((estado == ESPERA) || (estado == TRANSMISSAO)) begin
                timer <= tick ? 16'd0 : (timer + 16'd1);
            end else begin
                timer <= 16'd0;
            end

            // Capture grant and byte on entry to PREPARACAO (only reachable from INICIAL).
            if ((estado == INICIAL) && (proximo == PREPARACAO)) begin
                concede_b   <= escolha_b;
                dados_ascii <= escolha_b ? dados_b : dados_a;
            end

            if (estado == FINAL) begin
                ultimo_b <= concede_b;
            end

            zera    <= (proximo == PREPARACAO);
            carrega <= (proximo == PREPARACAO);
            conta   <= (proximo == TRANSMISSAO);
            desloca <= (proximo == TRANSMISSAO);
            ack_a   <= (proximo == PREPARACAO) && !escolha_b;
            ack_b   <= (proximo == PREPARACAO) && escolha_b;
            pronto  <= (proximo == FINAL);
            ocupado <= (proximo != INICIAL);
        end
    end

endmodule

// File: tb/tb_tx_serial_escalonador.sv
// -----------------------------------------------------------------------------
// tb_tx_serial_escalonador
// Directed self-checking bench for tx_serial_escalonador with CLKS_POR_BIT=4.
// A small model of the datapath bit counter produces fim (count reaches 12
// after twelve conta pulses, cleared by zera).
// -----------------------------------------------------------------------------
module tb_tx_serial_escalonador;

    logic       clock;
    logic       reset;
    logic       req_a;
    logic       req_b;
    logic [7:0] dados_a;
    logic [7:0] dados_b;
    logic       fim;
    logic       zera;
    logic       carrega;
    logic       conta;
    logic       desloca;
    logic [7:0] dados_ascii;
    logic       ack_a;
    logic       ack_b;
    logic       pronto;
    logic       ocupado;
    logic [3:0] db_estado;

    logic       fim_force;
    logic [3:0] bitcnt;
    logic [7:0] strobes;

    int n_checks;
    int n_pass;

    tx_serial_escalonador #(.CLKS_POR_BIT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_a       (req_a),
        .req_b       (req_b),
        .dados_a     (dados_a),
        .dados_b     (dados_b),
        .fim         (fim),
        .zera        (zera),
        .carrega     (carrega),
        .conta       (conta),
        .desloca     (desloca),
        .dados_ascii (dados_ascii),
        .ack_a       (ack_a),
        .ack_b       (ack_b),
        .pronto      (pronto),
        .ocupado     (ocupado),
        .db_estado   (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Datapath bit counter model
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bitcnt <= 4'd0;
        end else if (zera) begin
            bitcnt <= 4'd0;
        end else if (conta) begin
            bitcnt <= bitcnt + 4'd1;
        end
    end

    assign fim     = (bitcnt == 4'd12) | fim_force;
    assign strobes = {zera, carrega, conta, desloca, ack_a, ack_b, pronto, ocupado};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Step until carrega is seen (bounded); checks it took exactly one cycle.
    task automatic wait_prep(input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt++;
            if (carrega) break;
        end
        check({tag, "_prep"}, {15'd0, carrega}, 16'd1);
        check({tag, "_gap"}, 16'(cnt), 16'd1);
        check({tag, "_estado"}, {12'd0, db_estado}, 16'd1);
    endtask

    // From PREPARACAO at t0, check desloca/conta at t0+4k+1, pronto at t0+51, idle at t0+52.
    task automatic frame_tail(input string tag);
        logic exp_des;
        for (int n = 1; n <= 52; n++) begin
            step();
            exp_des = (n >= 5) && (n <= 49) && (((n - 1) % 4) == 0);
            check({tag, "_desloca_conta"}, {14'd0, desloca, conta}, {14'd0, exp_des, exp_des});
            check({tag, "_pronto"}, {15'd0, pronto}, {15'd0, (n == 51)});
        end
        check({tag, "_end_estado"}, {12'd0, db_estado}, 16'd0);
        check({tag, "_end_ocupado"}, {15'd0, ocupado}, 16'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        dados_a   = 8'h00;
        dados_b   = 8'h00;
        fim_force = 1'b0;

        // Reset state, before any clock edge
        #1 reset = 1'b1;
        #2;
        check("rst_estado", {12'd0, db_estado}, 16'd0);
        check("rst_strobes", {8'd0, strobes}, 16'd0);
        check("rst_dados", {8'd0, dados_ascii}, 16'd0);
        step();
        step();
        reset = 1'b0;

        // Idle: nothing moves for 100 cycles
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_estado", {12'd0, db_estado}, 16'd0);
            check("idle_strobes", {8'd0, strobes}, 16'd0);
        end

        // Single request from A
        dados_a = 8'h55;
        req_a   = 1'b1;
        step();
        check("a_estado", {12'd0, db_estado}, 16'd1);
        check("a_strobes", {8'd0, strobes}, 16'b0000_0000_1100_1001);
        check("a_dados", {8'd0, dados_ascii}, 16'h0055);
        req_a = 1'b0;
        frame_tail("a");
        check("a_hold", {8'd0, dados_ascii}, 16'h0055);

        // Reset pulse to restore last-granted=B, then simultaneous requests
        reset = 1'b1;
        #1;
        check("rst2_strobes", {8'd0, strobes}, 16'd0);
        check("rst2_dados", {8'd0, dados_ascii}, 16'd0);
        step();
        reset   = 1'b0;
        dados_a = 8'hA1;
        dados_b = 8'hB2;
        req_a   = 1'b1;
        req_b   = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_prep("rr");
            check("rr_ack", {14'd0, ack_a, ack_b}, (f == 1) ? 16'b01 : 16'b10);
            check("rr_dados", {8'd0, dados_ascii}, (f == 1) ? 16'h00B2 : 16'h00A1);
            if (f == 2) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            frame_tail("rr");
        end

        // fim forced in the same ESPERA cycle as a tick
        dados_a = 8'h3C;
        req_a   = 1'b1;
        wait_prep("fim");
        check("fim_ack", {14'd0, ack_a, ack_b}, 16'b10);
        req_a = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("fim_pre_estado", {12'd0, db_estado}, 16'd2);
        fim_force = 1'b1;
        step();
        fim_force = 1'b0;
        check("fim_estado", {12'd0, db_estado}, 16'd4);
        check("fim_desloca", {15'd0, desloca}, 16'd0);
        check("fim_pronto", {15'd0, pronto}, 16'd1);
        step();
        check("fim_back_idle", {12'd0, db_estado}, 16'd0);

        // Reset mid-frame at t0+20
        dados_a = 8'h0F;
        req_a   = 1'b1;
        wait_prep("mid");
        req_a = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("mid_busy", {15'd0, ocupado}, 16'd1);
        reset   = 1'b1;
        req_b   = 1'b1;
        dados_b = 8'h99;
        #1;
        check("mid_rst_estado", {12'd0, db_estado}, 16'd0);
        check("mid_rst_strobes", {8'd0, strobes}, 16'd0);
        check("mid_rst_dados", {8'd0, dados_ascii}, 16'd0);
        step();
        check("mid_rst_hold", {8'd0, strobes}, 16'd0);
        reset = 1'b0;
        wait_prep("mid_b");
        check("mid_b_ack", {14'd0, ack_a, ack_b}, 16'b01);
        check("mid_b_dados", {8'd0, dados_ascii}, 16'h0099);
        req_b = 1'b0;
        frame_tail("mid_b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
